// File: rtl/wsacc_pkg.sv
// Shared wsacc types: window generator FSM states and the 3x3 window bus seen by the PE data_i port.
package wsacc_pkg;
  localparam int KERNEL_DIM = 3;
  localparam int WIN_ELEMS  = KERNEL_DIM * KERNEL_DIM;
  localparam int PIX_W      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } wingen_state_t;

  // Element index r*3+c, r=0 oldest row, c=0 leftmost column.
  typedef logic [WIN_ELEMS-1:0][PIX_W-1:0] window_t;
endpackage

// File: rtl/wsacc_line_buffer.sv
// One image row of pixels indexed by column; write is registered, the read at the same address returns the old word.
module wsacc_line_buffer #(
  parameter int dataWidth = 8,
  parameter int depth     = 64,
  parameter int addrWidth = $clog2(depth)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [addrWidth-1:0] addr,
  input  logic [dataWidth-1:0] wdata,
  output logic [dataWidth-1:0] rdata
);
  logic [dataWidth-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/wsacc_window_gen.sv
// Raster-order pixel stream to 3x3 windows (no padding, stride 1); window valid one cycle after its last pixel, input stalls while a window waits.
// Define WSACC_WINGEN_STRIDE2_EN to add cfg_stride2, which keeps only windows at even offsets.
module wsacc_window_gen
  import wsacc_pkg::*;
#(
  parameter int dataWidth      = 8,
  parameter int maxWidth       = 64,
  parameter int maxHeight      = 64,
  parameter int windowElements = 9
) (
  input  logic                                          clk,
  input  logic                                          nrst,
  input  logic                                          start,
  input  logic [$clog2(maxWidth+1)-1:0]                 cfg_width,
  input  logic [$clog2(maxHeight+1)-1:0]                cfg_height,
`ifdef WSACC_WINGEN_STRIDE2_EN
  input  logic                                          cfg_stride2,
`endif
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [dataWidth-1:0]                          in_data,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [windowElements-1:0][dataWidth-1:0]      out_data,
  output logic                                          busy,
  output logic                                          done
);
  localparam int WW = $clog2(maxWidth+1);
  localparam int HW = $clog2(maxHeight+1);
  localparam int AW = $clog2(maxWidth);

  wingen_state_t                 state;
  logic [WW-1:0]                 w_q;
  logic [HW-1:0]                 h_q;
  logic [WW-1:0]                 col;
  logic [HW-1:0]                 row;
  logic [dataWidth-1:0]          lb_a_rd;
  logic [dataWidth-1:0]          lb_b_rd;
  logic [KERNEL_DIM-1:0][dataWidth-1:0] new_col;
  logic                          accept;
  logic                          last_col;
  logic                          last_row;
  logic                          win_ok;

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);
  assign last_col = (col == w_q - 1'b1);
  assign last_row = (row == h_q - 1'b1);
  assign new_col  = {in_data, lb_a_rd, lb_b_rd};

`ifdef WSACC_WINGEN_STRIDE2_EN
  logic s2_q;
  // row-2 and col-2 are even exactly when row and col are even.
  assign win_ok = (row >= HW'(2)) && (col >= WW'(2)) && (!s2_q || (!row[0] && !col[0]));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                       s2_q <= 1'b0;
    else if (state == IDLE && start) s2_q <= cfg_stride2;
  end
`else
  assign win_ok = (row >= HW'(2)) && (col >= WW'(2));
`endif

  wsacc_line_buffer #(.dataWidth(dataWidth), .depth(maxWidth)) u_lb_a (
    .clk   (clk),
    .we    (accept),
    .addr  (col[AW-1:0]),
    .wdata (in_data),
    .rdata (lb_a_rd)
  );

  wsacc_line_buffer #(.dataWidth(dataWidth), .depth(maxWidth)) u_lb_b (
    .clk   (clk),
    .we    (accept),
    .addr  (col[AW-1:0]),
    .wdata (lb_a_rd),
    .rdata (lb_b_rd)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      w_q       <= '0;
      h_q       <= '0;
      row       <= '0;
      col       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          w_q   <= cfg_width;
          h_q   <= cfg_height;
          row   <= '0;
          col   <= '0;
          state <= RUN;
        end
        RUN: if (accept) begin
          if (last_col) begin
            col <= '0;
            if (last_row) state <= DRAIN;
            else          row   <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        DRAIN: if (!out_valid || out_ready) begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A new window replaces a consumed one in the same cycle, so there is no bubble.
      out_valid <= (accept && win_ok) || (out_valid && !out_ready);

      // out_data doubles as the 3x3 shift register; it only moves on accept, which a stall blocks.
      if (accept) begin
        for (int r = 0; r < KERNEL_DIM; r++) begin
          out_data[r*KERNEL_DIM+0] <= out_data[r*KERNEL_DIM+1];
          out_data[r*KERNEL_DIM+1] <= out_data[r*KERNEL_DIM+2];
          out_data[r*KERNEL_DIM+2] <= new_col[r];
        end
      end
    end
  end
endmodule

// File: tb/tb_wsacc_window_gen.sv
// Directed bench for wsacc_window_gen: frames of counting pixels checked against a reference window model.
module tb_wsacc_window_gen;
  logic        clk;
  logic        nrst;
  logic        start;
  logic [6:0]  cfg_width;
  logic [6:0]  cfg_height;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [8:0][7:0] out_data;
  logic        busy;
  logic        done;
`ifdef WSACC_WINGEN_STRIDE2_EN
  logic        cfg_stride2;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit tog = 0;
  logic [71:0] got_q[$];
  logic        prev_stall = 0;
  logic [71:0] prev_data = '0;

  wsacc_window_gen dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
`ifdef WSACC_WINGEN_STRIDE2_EN
    .cfg_stride2(cfg_stride2),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Capture handshaken windows, count done pulses, and check that stalled windows hold.
  initial begin
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        check("hold_vld", 72'(out_valid), 72'd1);
        check("hold_dat", out_data, prev_data);
      end
      if (out_valid && out_ready) got_q.push_back(out_data);
      if (done) done_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = tog ? ~out_ready : 1'b1;
    end
  end

  function automatic logic [71:0] exp_win(input int w, input int base, input int r, input int c);
    logic [71:0] res;
    int v;
    res = '0;
    for (int k = 0; k < 9; k++) begin
      v = base + (r - 2 + k / 3) * w + (c - 2 + k % 3);
      res[k*8 +: 8] = v[7:0];
    end
    return res;
  endfunction

  task automatic start_frame(input int w, input int h, input bit s2);
    @(posedge clk);
    #1;
    start      = 1'b1;
    cfg_width  = 7'(w);
    cfg_height = 7'(h);
`ifdef WSACC_WINGEN_STRIDE2_EN
    cfg_stride2 = s2;
`else
    if (s2) $display("stride2 requested without WSACC_WINGEN_STRIDE2_EN");
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int base, input bit rnd);
    int t;
    for (int i = 0; i < n; i++) begin
      if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = 8'(base + i);
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 200) begin
        t++;
        @(negedge clk);
      end
      if (!in_ready) check("in_rdy_timeout", 72'd0, 72'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    @(negedge clk);
    while (!done && t < 300) begin
      t++;
      @(negedge clk);
    end
    if (!done) check("done_timeout", 72'd0, 72'd1);
  endtask

  task automatic check_frame(input string tag, input int w, input int h, input int base, input int step);
    logic [71:0] exp_q[$];
    for (int r = 2; r < h; r += step)
      for (int c = 2; c < w; c += step)
        exp_q.push_back(exp_win(w, base, r, c));
    check({tag, "_nwin"}, 72'(got_q.size()), 72'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_win"}, got_q[i], exp_q[i]);
    check({tag, "_done"}, 72'(done_cnt), 72'd1);
    check({tag, "_busy"}, 72'(busy), 72'd0);
  endtask

  task automatic clear_scoreboard();
    got_q.delete();
    done_cnt = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_vld"}, 72'(out_valid), 72'd0);
    check({tag, "_dat"}, out_data, 72'd0);
    check({tag, "_rdy"}, 72'(in_ready), 72'd0);
    check({tag, "_busy"}, 72'(busy), 72'd0);
    check({tag, "_done"}, 72'(done), 72'd0);
  endtask

  initial begin
    nrst = 1'b0;
    start = 1'b0;
    cfg_width = '0;
    cfg_height = '0;
    in_valid = 1'b0;
    in_data = '0;
`ifdef WSACC_WINGEN_STRIDE2_EN
    cfg_stride2 = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    @(posedge clk);
    #1;
    nrst = 1'b1;

    // 4x4, downstream always ready
    clear_scoreboard();
    start_frame(4, 4, 1'b0);
    check("run_busy", 72'(busy), 72'd1);
    feed(16, 0, 1'b0);
    wait_done();
    check_frame("f4x4", 4, 4, 0, 1);

    // 4x4 with out_ready toggling and gappy input
    clear_scoreboard();
    tog = 1'b1;
    start_frame(4, 4, 1'b0);
    feed(16, 0, 1'b1);
    wait_done();
    check_frame("f4x4_bp", 4, 4, 0, 1);
    tog = 1'b0;

    // minimum frame, then a back-to-back 5x3 frame
    clear_scoreboard();
    start_frame(3, 3, 1'b0);
    feed(9, 1, 1'b0);
    wait_done();
    check_frame("f3x3", 3, 3, 1, 1);
    clear_scoreboard();
    start_frame(5, 3, 1'b0);
    feed(15, 100, 1'b0);
    wait_done();
    check_frame("f5x3", 5, 3, 100, 1);

    // start during RUN must not disturb the frame
    clear_scoreboard();
    start_frame(4, 4, 1'b0);
    feed(5, 0, 1'b0);
    start_frame(8, 8, 1'b0);
    feed(11, 5, 1'b0);
    wait_done();
    check_frame("f4x4_restart", 4, 4, 0, 1);

    // reset mid-frame
    clear_scoreboard();
    start_frame(8, 8, 1'b0);
    feed(7, 0, 1'b0);
    nrst = 1'b0;
    @(negedge clk);
    check_reset_state("mid_rst");
    repeat (2) @(negedge clk);
    check("mid_rst_nodone", 72'(done_cnt), 72'd0);
    check("mid_rst_nwin", 72'(got_q.size()), 72'd0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    clear_scoreboard();
    start_frame(4, 4, 1'b0);
    feed(16, 0, 1'b0);
    wait_done();
    check_frame("f4x4_post_rst", 4, 4, 0, 1);

`ifdef WSACC_WINGEN_STRIDE2_EN
    clear_scoreboard();
    start_frame(6, 6, 1'b1);
    feed(36, 0, 1'b0);
    wait_done();
    check_frame("f6x6_s2", 6, 6, 0, 2);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wsacc_window_gen.md
Name: wsacc_window_gen

Overview:
Streaming 3x3 window generator that sits directly upstream of the wsacc PE array.
- Accepts one activation pixel per handshake in raster order and buffers two previous rows in line buffers.
- Emits a packed 9-element window per valid convolution position (no padding, stride 1).
- The output bus layout matches the PE `data_i` port exactly.

Parameters:
- dataWidth, 8: pixel width in bits.
- maxWidth, 64: maximum image width; sets line-buffer depth.
- maxHeight, 64: maximum image height.
- windowElements, 9: fixed; 3x3 kernel. Other values are unsupported.

Ports:
- clk  in  1  clock.
- nrst  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; latches cfg and begins a frame.
- cfg_width  in  $clog2(maxWidth+1)  image columns, legal 3..maxWidth.
- cfg_height  in  $clog2(maxHeight+1)  image rows, legal 3..maxHeight.
- in_valid  in  1  pixel valid.
- in_ready  out  1  pixel accepted when in_valid && in_ready.
- in_data  in  dataWidth  pixel.
- out_valid  out  1  window valid.
- out_ready  in  1  downstream accepts the window.
- out_data  out  [windowElements-1:0][dataWidth-1:0]  window; index = r*3+c, with r=0 the oldest row and c=0 the leftmost column. Element 8 is the newest pixel.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse when a frame is fully emitted.

Behaviour:
- Reset values: out_valid=0, out_data=0, in_ready=0, busy=0, done=0, FSM=IDLE, row/col=0. Line-buffer contents need no reset.
- FSM:
  - IDLE: in_ready=0. start latches cfg_width/cfg_height, clears row/col, goes to RUN.
  - RUN: in_ready = !out_valid || out_ready. Accepting the last pixel (row==H-1, col==W-1) moves to DRAIN.
  - DRAIN: in_ready=0. Once out_valid==0 or the final window handshakes, pulse done for one cycle and go to IDLE.
- start outside IDLE is ignored. cfg is only sampled on start.
- Line buffers: lb_a holds row r-1, lb_b holds row r-2, both indexed by col. On accept at column c:
  - the new column is {lb_b[c], lb_a[c], in_data};
  - write lb_b[c] <= lb_a[c] and lb_a[c] <= in_data;
  - the 3x3 register shifts left by one column.
- Counters: col wraps W-1 -> 0 and increments row at the same time. No wrap past H-1; the FSM leaves RUN.
- A window is produced when the accepted pixel has row>=2 && col>=2. Stale columns from the previous row are flushed by the col>=2 rule.
- Latency: out_valid rises the cycle after the completing pixel is accepted.
- out_data is held stable while out_valid && !out_ready.
- Simultaneous output handshake and new window-producing accept in the same cycle: out_valid stays 1 and out_data updates. No bubble, full throughput.
- Accept of a non-window pixel during an output handshake: out_valid drops to 0.
- Window count per frame = (W-2)*(H-2).
- Reset mid-frame: returns to IDLE immediately. The partial frame is discarded and no done pulse is issued.
- Arithmetic: none on data; pixels pass through unchanged, with signedness left to the PE.

Optional Feature:
- Macro: WSACC_WINGEN_STRIDE2_EN.
- When defined: adds input port cfg_stride2 (1 bit, latched on start). When set, a window is produced only if (row-2) and (col-2) are both even. Line-buffer and shift updates are unchanged.
- When undefined: the port is absent and stride is always 1.

Decomposition:
- Shared package wsacc_pkg:
  - typedef wingen_state_t {IDLE, RUN, DRAIN};
  - localparam KERNEL_DIM=3;
  - typedef for the window type, packed [8:0][dataWidth-1:0], used by both this block and the PE.
- Sub-module wsacc_line_buffer: single-port-style array, depth maxWidth, synchronous write plus same-cycle read at the same address (read returns the old value). Instantiate it twice.

Test Plan:
- 4x4 frame, pixels 0..15, out_ready=1 -> 4 windows: {0,1,2,4,5,6,8,9,10}, {1,2,3,5,6,7,9,10,11}, {4,5,6,8,9,10,12,13,14}, {5,6,7,9,10,11,13,14,15}; then done pulses once and busy falls.
- Same frame with out_ready toggling 1010... and in_valid random -> identical 4 windows; out_data stable while stalled; no drops or duplicates.
- Minimum 3x3 frame, pixels 1..9 -> exactly one window {1..9}; then back-to-back start of a 5x3 frame -> 3 windows, with no stale data from the previous frame appearing.
- start pulsed during RUN with different cfg -> ignored; the frame completes with the original W/H window count.
- nrst asserted after 7 pixels of an 8x8 frame -> all outputs return to reset values; a new 4x4 frame then gives the first-test results.
- WSACC_WINGEN_STRIDE2_EN with cfg_stride2=1, 6x6 frame of pixels 0..35 -> 4 windows, with top-left pixels 0, 2, 12, 14.
